// File: rtl/vector_element_sequencer.sv
// Steps one vector instruction over VL elements in groups of four, issuing each
// group to the PE array and writing it back before the next group starts.
module vector_element_sequencer #(
  parameter  int VLEN = 32,
  localparam int VL_W = $clog2(VLEN) + 1
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [4:0]      instr_vs1,
  input  logic [4:0]      instr_vs2,
  input  logic [4:0]      instr_vd,
  input  logic [1:0]      instr_vsew,
  input  logic [VL_W-1:0] instr_vl,
  input  logic            instr_widening,
  output logic [4:0]      vs1_addr,
  output logic [4:0]      vs2_addr,
  output logic [4:0]      vd_addr,
  output logic [1:0]      vsew,
  output logic            widening_op,
  output logic [1:0]      elements_to_write,
  output logic            write,
  output logic            pe_start,
  input  logic            pe_done,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  localparam int CNT_W = VL_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [VL_W-1:0]  r_vl;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rejected;

  logic             w_accept;
  logic             w_instr_illegal;
  logic [CNT_W-1:0] w_remain;
  logic             w_last;
  logic [1:0]       w_etw;
  logic [4:0]       w_src_step;
  logic [4:0]       w_dst_step;

  assign w_accept        = (r_state == S_IDLE) & instr_valid;
  assign w_instr_illegal = (instr_vsew == 2'd3) | (instr_widening & instr_vsew[1]);
  assign w_remain        = {1'b0, r_vl} - r_cnt;
  assign w_last          = (r_cnt + CNT_W'(4)) >= {1'b0, r_vl};
  assign w_etw           = (w_remain >= CNT_W'(4)) ? 2'd0 : w_remain[1:0];
  assign w_src_step      = 5'd1 << r_vsew_shift(vsew, 1'b0);
  assign w_dst_step      = 5'd1 << r_vsew_shift(vsew, widening_op);

  // Destination groups are twice as wide for widening ops.
  function automatic logic [2:0] r_vsew_shift(input logic [1:0] sew, input logic wide);
    return {1'b0, sew} + {2'b0, wide};
  endfunction

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          if (w_instr_illegal || (instr_vl == '0)) w_next = S_DONE;
          else                                     w_next = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_EXEC;
      S_EXEC:  if (pe_done) w_next = S_WRITE;
      S_WRITE: w_next = w_last ? S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Every output is decoded from the next state so it lines up with the state it belongs to.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      instr_ready       <= 1'b1;
      busy              <= 1'b0;
      pe_start          <= 1'b0;
      write             <= 1'b0;
      done              <= 1'b0;
      illegal           <= 1'b0;
      elements_to_write <= 2'd0;
      vs1_addr          <= 5'd0;
      vs2_addr          <= 5'd0;
      vd_addr           <= 5'd0;
      vsew              <= 2'd0;
      widening_op       <= 1'b0;
      r_vl              <= '0;
      r_cnt             <= '0;
      r_rejected        <= 1'b0;
    end else begin
      instr_ready <= (w_next == S_IDLE);
      busy        <= (w_next != S_IDLE);
      pe_start    <= (w_next == S_ISSUE);
      write       <= (w_next == S_WRITE);
      done        <= (w_next == S_DONE);
      illegal     <= (w_next == S_DONE) & (w_accept ? w_instr_illegal : r_rejected);

      if (w_accept) begin
        vs1_addr    <= instr_vs1;
        vs2_addr    <= instr_vs2;
        vd_addr     <= instr_vd;
        vsew        <= instr_vsew;
        widening_op <= instr_widening;
        r_vl        <= instr_vl;
        r_cnt       <= '0;
        r_rejected  <= w_instr_illegal;
      end

      if ((r_state == S_EXEC) && pe_done) elements_to_write <= w_etw;

      // Addresses move on only after the group has been written back.
      if (r_state == S_WRITE) begin
        r_cnt    <= r_cnt + CNT_W'(4);
        vs1_addr <= vs1_addr + w_src_step;
        vs2_addr <= vs2_addr + w_src_step;
        vd_addr  <= vd_addr + w_dst_step;
      end
    end
  end

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Bench for vector_element_sequencer: directed table, hand-written corner sequences
// and randomized instructions checked against a group-level reference model.
module tb_vector_element_sequencer;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [4:0] instr_vs1, instr_vs2, instr_vd;
  logic [1:0] instr_vsew;
  logic [5:0] instr_vl;
  logic       instr_widening;
  logic [4:0] vs1_addr, vs2_addr, vd_addr;
  logic [1:0] vsew;
  logic       widening_op;
  logic [1:0] elements_to_write;
  logic       write, pe_start, pe_done, busy, done, illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vector_element_sequencer dut (
    .clk(clk), .n_reset(n_reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_vs1(instr_vs1), .instr_vs2(instr_vs2), .instr_vd(instr_vd),
    .instr_vsew(instr_vsew), .instr_vl(instr_vl), .instr_widening(instr_widening),
    .vs1_addr(vs1_addr), .vs2_addr(vs2_addr), .vd_addr(vd_addr),
    .vsew(vsew), .widening_op(widening_op), .elements_to_write(elements_to_write),
    .write(write), .pe_start(pe_start), .pe_done(pe_done),
    .busy(busy), .done(done), .illegal(illegal)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int vs1;
    int vs2;
    int vd;
    int etw;
  } wr_t;

  // Drives one instruction, answers pe_start with a random 1..dmax cycle delay,
  // and checks every write against a group-by-group reference.
  task automatic run_instr(input int a1, input int a2, input int ad, input int sew,
                           input int vl, input int wid, input int dmax,
                           output int nw, output int l1, output int ld, output int letw,
                           output int ill, output int dcyc);
    wr_t q[$];
    wr_t e;
    wr_t got;
    int  exp_ill, groups, lat_exp, cd, nps, d, rem;
    exp_ill = (sew == 3 || (wid == 1 && sew >= 2)) ? 1 : 0;
    groups  = (exp_ill == 1) ? 0 : (vl + 3) / 4;
    for (int k = 0; k < groups; k++) begin
      rem   = vl - 4 * k;
      e.vs1 = (a1 + k * (1 << sew)) % 32;
      e.vs2 = (a2 + k * (1 << sew)) % 32;
      e.vd  = (ad + k * (1 << (sew + wid))) % 32;
      e.etw = (rem >= 4) ? 0 : rem;
      q.push_back(e);
    end
    @(negedge clk);
    instr_vs1 = 5'(a1); instr_vs2 = 5'(a2); instr_vd = 5'(ad);
    instr_vsew = 2'(sew); instr_vl = 6'(vl); instr_widening = 1'(wid);
    instr_valid = 1'b1;
    chk("ready_idle", {31'd0, instr_ready}, 1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    cd = 0; nps = 0; nw = 0; dcyc = -1; ill = 0; lat_exp = 1;
    l1 = -1; ld = -1; letw = -1;
    for (int t = 1; t <= 400 && dcyc < 0; t++) begin
      @(negedge clk);
      pe_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) pe_done = 1'b1;
      end
      if (pe_start) begin
        nps++;
        d = $urandom_range(dmax, 1);
        cd = d;
        lat_exp += d + 2;
      end
      if (write) begin
        nw++;
        l1 = vs1_addr; ld = vd_addr; letw = elements_to_write;
        if (q.size() == 0) begin
          chk("extra_write", 1, 0);
        end else begin
          got = q.pop_front();
          chk("vs1_addr", {27'd0, vs1_addr}, got.vs1);
          chk("vs2_addr", {27'd0, vs2_addr}, got.vs2);
          chk("vd_addr", {27'd0, vd_addr}, got.vd);
          chk("elements_to_write", {30'd0, elements_to_write}, got.etw);
          chk("vsew_out", {30'd0, vsew}, sew);
          chk("widening_out", {31'd0, widening_op}, wid);
        end
      end
      chk("busy_active", {31'd0, busy}, 1);
      if (done) begin
        dcyc = t;
        ill  = illegal;
      end else if (illegal) begin
        chk("illegal_without_done", 1, 0);
      end
    end
    pe_done = 1'b0;
    if (dcyc < 0) chk("done_timeout", 0, 1);
    chk("done_latency", dcyc, lat_exp);
    chk("pe_start_count", nps, groups);
    chk("write_count", nw, groups);
    chk("illegal_flag", ill, exp_ill);
    @(negedge clk);
    chk("ready_after", {31'd0, instr_ready}, 1);
    chk("busy_after", {31'd0, busy}, 0);
    chk("done_pulse", {31'd0, done}, 0);
  endtask

  typedef struct {
    int vs1, vs2, vd, sew, vl, wid;
    int nw, lvs1, lvd, letw, ill, lat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int nw, l1, ld, letw, ill, dcyc;

    tbl[0] = '{4, 8, 12, 0, 10, 0,   3, 6, 14, 2, 0, 10};
    tbl[1] = '{8, 0, 16, 2, 6, 0,    2, 12, 20, 2, 0, 7};
    tbl[2] = '{4, 12, 8, 0, 8, 1,    2, 5, 10, 0, 0, 7};
    tbl[3] = '{3, 4, 5, 1, 0, 0,     0, 0, 0, 0, 0, 1};
    tbl[4] = '{1, 2, 3, 2, 8, 1,     0, 0, 0, 0, 1, 1};
    tbl[5] = '{1, 2, 3, 3, 4, 0,     0, 0, 0, 0, 1, 1};
    tbl[6] = '{30, 31, 28, 1, 12, 1, 3, 2, 4, 0, 0, 10};
    tbl[7] = '{0, 16, 0, 0, 32, 0,   8, 7, 7, 0, 0, 25};
    tbl[8] = '{2, 3, 6, 1, 1, 0,     1, 2, 6, 1, 0, 4};
    tbl[9] = '{5, 6, 7, 0, 7, 0,     2, 6, 8, 3, 0, 7};

    n_reset = 1'b0; instr_valid = 1'b0; pe_done = 1'b0;
    instr_vs1 = '0; instr_vs2 = '0; instr_vd = '0;
    instr_vsew = '0; instr_vl = '0; instr_widening = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_write", {31'd0, write}, 0);
    chk("rst_pe_start", {31'd0, pe_start}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_illegal", {31'd0, illegal}, 0);
    chk("rst_vd_addr", {27'd0, vd_addr}, 0);
    n_reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].vs1, tbl[i].vs2, tbl[i].vd, tbl[i].sew, tbl[i].vl, tbl[i].wid, 1,
                nw, l1, ld, letw, ill, dcyc);
      chk("tbl_writes", nw, tbl[i].nw);
      chk("tbl_illegal", ill, tbl[i].ill);
      chk("tbl_latency", dcyc, tbl[i].lat);
      if (tbl[i].nw > 0) begin
        chk("tbl_last_vs1", l1, tbl[i].lvs1);
        chk("tbl_last_vd", ld, tbl[i].lvd);
        chk("tbl_last_etw", letw, tbl[i].letw);
      end
    end

    // Slow PE with a second instruction held on the input throughout.
    @(negedge clk);
    instr_vs1 = 5'd1; instr_vs2 = 5'd2; instr_vd = 5'd2;
    instr_vsew = 2'd0; instr_vl = 6'd4; instr_widening = 1'b0;
    instr_valid = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= 13; t++) begin
      @(negedge clk);
      pe_done = (t == 1 || t == 6 || t == 11);
      if (t == 1) begin
        instr_vs1 = 5'd9; instr_vs2 = 5'd11; instr_vd = 5'd10;
      end
      if (t == 10) instr_valid = 1'b0;
      chk("held_write", {31'd0, write}, (t == 7 || t == 12) ? 1 : 0);
      chk("held_pe_start", {31'd0, pe_start}, (t == 1 || t == 10) ? 1 : 0);
      chk("held_done", {31'd0, done}, (t == 8 || t == 13) ? 1 : 0);
      chk("held_ready", {31'd0, instr_ready}, (t == 9) ? 1 : 0);
      if (t == 7)  chk("held_vs1_a", {27'd0, vs1_addr}, 1);
      if (t == 12) chk("held_vs1_b", {27'd0, vs1_addr}, 9);
    end
    @(negedge clk);
    pe_done = 1'b0;
    chk("held_idle", {31'd0, instr_ready}, 1);

    // Reset while waiting on the PE array.
    instr_vs1 = 5'd0; instr_vs2 = 5'd4; instr_vd = 5'd8;
    instr_vsew = 2'd0; instr_vl = 6'd8; instr_widening = 1'b0;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("exec_busy", {31'd0, busy}, 1);
    n_reset = 1'b0;
    #1;
    chk("abort_write", {31'd0, write}, 0);
    chk("abort_pe_start", {31'd0, pe_start}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_ready", {31'd0, instr_ready}, 1);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      pe_done = (t < 2);
      chk("post_rst_write", {31'd0, write}, 0);
      chk("post_rst_done", {31'd0, done}, 0);
      chk("post_rst_pe_start", {31'd0, pe_start}, 0);
      chk("post_rst_ready", {31'd0, instr_ready}, 1);
    end
    pe_done = 1'b0;
    run_instr(20, 24, 28, 0, 4, 0, 1, nw, l1, ld, letw, ill, dcyc);
    chk("post_rst_writes", nw, 1);
    chk("post_rst_latency", dcyc, 4);

    for (int i = 0; i < 40; i++) begin
      run_instr($urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(31, 0),
                $urandom_range(3, 0), $urandom_range(32, 0), $urandom_range(1, 0), 4,
                nw, l1, ld, letw, ill, dcyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
